// File: rtl/serv_vpu_pkg.sv
// Shared definitions for the SERV vector-issue slice: command type encodings,
// field widths/offsets, the packed 29-bit command and the issue FSM states.
package serv_vpu_pkg;

  localparam logic [1:0] TYPE_VARITH   = 2'b01;
  localparam logic [1:0] TYPE_LOAD_FP  = 2'b10;
  localparam logic [1:0] TYPE_STORE_FP = 2'b11;

  localparam int TYPE_W   = 2;
  localparam int FUNCT6_W = 6;
  localparam int FUNCT3_W = 3;
  localparam int VREG_W   = 5;
  localparam int MOP_W    = 2;
  localparam int CMD_W    = 29;
  localparam int SCALAR_W = 32;
  localparam int ENTRY_W  = CMD_W + SCALAR_W;

  localparam int MOP_OFS    = 0;
  localparam int VM_OFS     = 2;
  localparam int VS2_OFS    = 3;
  localparam int VS1_OFS    = 8;
  localparam int VD_OFS     = 13;
  localparam int FUNCT3_OFS = 18;
  localparam int FUNCT6_OFS = 21;
  localparam int TYPE_OFS   = 27;

  typedef struct packed {
    logic [TYPE_W-1:0]   op_type;
    logic [FUNCT6_W-1:0] funct6;
    logic [FUNCT3_W-1:0] funct3;
    logic [VREG_W-1:0]   vd;
    logic [VREG_W-1:0]   vs1;
    logic [VREG_W-1:0]   vs2;
    logic                vm;
    logic [MOP_W-1:0]    mop;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/serv_vpu_issue_if.sv
// VPU command channel: valid/ready handshake carrying a command and its rs1 value.
interface serv_vpu_issue_if;
  import serv_vpu_pkg::*;

  logic                o_valid;
  logic                i_ready;
  cmd_t                o_cmd;
  logic [SCALAR_W-1:0] o_scalar;

  modport master (output o_valid, output o_cmd, output o_scalar, input i_ready);
  modport slave  (input o_valid, input o_cmd, input o_scalar, output i_ready);

endinterface

// File: rtl/serv_vpu_fifo.sv
// Issue FIFO: DEPTH entries (power of two) of {cmd, scalar}; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module serv_vpu_fifo
  import serv_vpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/serv_vpu_issue.sv
// Collects decode fields and a bit-serial rs1 operand, then queues a VPU command.
// Optional macro SERV_VPU_ISSUE_BYPASS_EN forwards PUSH data straight out when the FIFO is empty.
module serv_vpu_issue
  import serv_vpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_vector_op,
  input  logic       i_load_fp_op,
  input  logic       i_store_fp_op,
  input  logic [2:0] i_funct3,
  input  logic [5:0] i_funct6,
  input  logic [4:0] i_vd,
  input  logic [4:0] i_vs1,
  input  logic [4:0] i_vs2,
  input  logic       i_vm,
  input  logic [1:0] i_mop,
  input  logic       i_cnt_en,
  input  logic       i_rs1,
  output logic       o_busy,
  serv_vpu_issue_if.master o_vpu
);

  state_t              r_state;
  cmd_t                r_cmd;
  logic [SCALAR_W-1:0] r_shift;
  logic [4:0]          r_cnt;

  logic               w_flag;
  logic [1:0]         w_type;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_out;
  logic               w_full;
  logic               w_empty;
  logic               w_in_push;
  logic               w_fifo_pop;
  logic               w_bypass;
  logic               w_accept;
  logic               w_push;

  assign w_flag     = i_vector_op | i_load_fp_op | i_store_fp_op;
  assign w_type     = i_vector_op  ? TYPE_VARITH  :
                      i_load_fp_op ? TYPE_LOAD_FP : TYPE_STORE_FP;
  assign w_entry    = {r_cmd, r_shift};
  assign w_in_push  = (r_state == S_PUSH);
  assign w_fifo_pop = ~w_empty & o_vpu.i_ready;

`ifdef SERV_VPU_ISSUE_BYPASS_EN
  assign w_bypass = w_in_push & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed command taken by the VPU this cycle never needs storage.
  assign w_accept = w_in_push & (~w_full | w_fifo_pop);
  assign w_push   = w_accept & ~(w_bypass & o_vpu.i_ready);
  assign o_busy   = w_in_push & ~w_accept;

  assign w_out          = ~w_empty ? w_head : (w_bypass ? w_entry : '0);
  assign o_vpu.o_valid  = ~w_empty | w_bypass;
  assign o_vpu.o_cmd    = cmd_t'(w_out[ENTRY_W-1:SCALAR_W]);
  assign o_vpu.o_scalar = w_out[SCALAR_W-1:0];

  // Issue sequencing: latch decode on start, gather 32 rs1 bits, then enqueue.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && w_flag) begin
            r_cmd   <= '{op_type: w_type, funct6: i_funct6, funct3: i_funct3,
                         vd: i_vd, vs1: i_vs1, vs2: i_vs2, vm: i_vm, mop: i_mop};
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (i_cnt_en) begin
            r_shift <= {i_rs1, r_shift[SCALAR_W-1:1]};
            r_cnt   <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (w_accept) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  serv_vpu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_fifo_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_serv_vpu_issue.sv
// Directed testbench for serv_vpu_issue: vector table plus multi-cycle sequences.
// Build with or without SERV_VPU_ISSUE_BYPASS_EN to match the DUT configuration.
module tb_serv_vpu_issue;
  import serv_vpu_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_vector_op;
  logic       i_load_fp_op;
  logic       i_store_fp_op;
  logic [2:0] i_funct3;
  logic [5:0] i_funct6;
  logic [4:0] i_vd;
  logic [4:0] i_vs1;
  logic [4:0] i_vs2;
  logic       i_vm;
  logic [1:0] i_mop;
  logic       i_cnt_en;
  logic       i_rs1;
  logic       o_busy;

  int checks = 0;
  int fails  = 0;

  serv_vpu_issue_if vpu ();

  serv_vpu_issue #(.DEPTH(2)) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_vector_op   (i_vector_op),
    .i_load_fp_op  (i_load_fp_op),
    .i_store_fp_op (i_store_fp_op),
    .i_funct3      (i_funct3),
    .i_funct6      (i_funct6),
    .i_vd          (i_vd),
    .i_vs1         (i_vs1),
    .i_vs2         (i_vs2),
    .i_vm          (i_vm),
    .i_mop         (i_mop),
    .i_cnt_en      (i_cnt_en),
    .i_rs1         (i_rs1),
    .o_busy        (o_busy),
    .o_vpu         (vpu.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vec;
    logic        ld;
    logic        st;
    logic [5:0]  f6;
    logic [2:0]  f3;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic        vm;
    logic [1:0]  mop;
    logic [31:0] rs1;
    logic [28:0] expCmd;
    logic [31:0] expScalar;
  } vec_t;

  vec_t tbl [3];

  localparam logic [31:0] V1_CMD = 32'h0800_2218;
  localparam logic [31:0] V2_CMD = 32'h155F_E08E;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReady(input logic v);
    vpu.i_ready = v;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One-cycle start pulse carrying the decode fields.
  task automatic applyStimulus(input logic vec, input logic ld, input logic st,
                               input logic [5:0] f6, input logic [2:0] f3,
                               input logic [4:0] vd, input logic [4:0] vs1,
                               input logic [4:0] vs2, input logic vm, input logic [1:0] mop);
    i_start = 1'b1; i_vector_op = vec; i_load_fp_op = ld; i_store_fp_op = st;
    i_funct6 = f6; i_funct3 = f3; i_vd = vd; i_vs1 = vs1; i_vs2 = vs2;
    i_vm = vm; i_mop = mop;
    tick();
    i_start = 1'b0; i_vector_op = 1'b0; i_load_fp_op = 1'b0; i_store_fp_op = 1'b0;
  endtask

  // Serially present bits first..last of data; gap cycles carry the wrong bit.
  task automatic shiftBits(input logic [31:0] data, input int first, input int last, input bit gapped);
    for (int b = first; b <= last; b++) begin
      if (gapped) begin
        i_cnt_en = 1'b0; i_rs1 = ~data[b];
        tick();
      end
      i_cnt_en = 1'b1; i_rs1 = data[b];
      tick();
    end
    i_cnt_en = 1'b0; i_rs1 = 1'b0;
  endtask

  task automatic drainOne(input string name);
    setReady(1'b1);
    tick();
    setReady(1'b0);
    checkOutput({name, "_drained"}, 32'(vpu.o_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = '{vec:1'b0, ld:1'b1, st:1'b0, f6:6'h2A, f3:3'd7, vd:5'd31, vs1:5'd0, vs2:5'd17,
               vm:1'b1, mop:2'b10, rs1:32'h1234_5678, expCmd:29'h155F_E08E, expScalar:32'h1234_5678};
    tbl[1] = '{vec:1'b0, ld:1'b0, st:1'b1, f6:6'h3F, f3:3'd2, vd:5'd5, vs1:5'd10, vs2:5'd20,
               vm:1'b0, mop:2'b11, rs1:32'hA5A5_0F0F, expCmd:29'h1FE8_AAA3, expScalar:32'hA5A5_0F0F};
    tbl[2] = '{vec:1'b1, ld:1'b0, st:1'b0, f6:6'h00, f3:3'd0, vd:5'd1, vs1:5'd2, vs2:5'd3,
               vm:1'b0, mop:2'b00, rs1:32'h0000_0000, expCmd:29'h0800_2218, expScalar:32'h0000_0000};

    i_rst = 1'b1; i_start = 1'b0; i_vector_op = 1'b0; i_load_fp_op = 1'b0; i_store_fp_op = 1'b0;
    i_funct3 = '0; i_funct6 = '0; i_vd = '0; i_vs1 = '0; i_vs2 = '0; i_vm = 1'b0; i_mop = '0;
    i_cnt_en = 1'b0; i_rs1 = 1'b0; vpu.i_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    i_rst = 1'b0;
    tick();
    checkOutput("rst_valid",  32'(vpu.o_valid),  32'd0);
    checkOutput("rst_busy",   32'(o_busy),       32'd0);
    checkOutput("rst_cmd",    32'(vpu.o_cmd),    32'd0);
    checkOutput("rst_scalar", vpu.o_scalar,      32'd0);

    // Single vector op with the consumer always ready
    $display("[TB] vector op, i_ready=1");
    setReady(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 2'b00);
    shiftBits(32'hDEAD_BEEF, 0, 31, 1'b0);
`ifdef SERV_VPU_ISSUE_BYPASS_EN
    checkOutput("vec_byp_valid",  32'(vpu.o_valid), 32'd1);
    checkOutput("vec_byp_cmd",    32'(vpu.o_cmd),   V1_CMD);
    checkOutput("vec_byp_scalar", vpu.o_scalar,     32'hDEAD_BEEF);
    tick();
    checkOutput("vec_byp_no_store", 32'(vpu.o_valid), 32'd0);
`else
    checkOutput("vec_push_valid", 32'(vpu.o_valid), 32'd0);
    tick();
    checkOutput("vec_valid",  32'(vpu.o_valid), 32'd1);
    checkOutput("vec_cmd",    32'(vpu.o_cmd),   V1_CMD);
    checkOutput("vec_scalar", vpu.o_scalar,     32'hDEAD_BEEF);
    tick();
    checkOutput("vec_one_pulse", 32'(vpu.o_valid), 32'd0);
`endif
    tick();
    checkOutput("vec_idle_valid", 32'(vpu.o_valid), 32'd0);
    setReady(1'b0);

    // Table of ops, consumer stalled until the entry is inspected
    for (int i = 0; i < 3; i++) begin
      $display("[TB] table vector %0d", i);
      applyStimulus(tbl[i].vec, tbl[i].ld, tbl[i].st, tbl[i].f6, tbl[i].f3,
                    tbl[i].vd, tbl[i].vs1, tbl[i].vs2, tbl[i].vm, tbl[i].mop);
      shiftBits(tbl[i].rs1, 0, 31, 1'b0);
      checkOutput("tbl_push_busy", 32'(o_busy), 32'd0);
`ifdef SERV_VPU_ISSUE_BYPASS_EN
      checkOutput("tbl_push_valid", 32'(vpu.o_valid), 32'd1);
`else
      checkOutput("tbl_push_valid", 32'(vpu.o_valid), 32'd0);
`endif
      tick();
      checkOutput("tbl_valid",  32'(vpu.o_valid), 32'd1);
      checkOutput("tbl_cmd",    32'(vpu.o_cmd),   32'(tbl[i].expCmd));
      checkOutput("tbl_scalar", vpu.o_scalar,     tbl[i].expScalar);
      tick();
      checkOutput("tbl_hold_cmd",    32'(vpu.o_cmd), 32'(tbl[i].expCmd));
      checkOutput("tbl_hold_scalar", vpu.o_scalar,   tbl[i].expScalar);
      drainOne("tbl");
    end

    // Backpressure: third load-fp op stalls in PUSH until a pop frees a slot
    $display("[TB] full FIFO backpressure");
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 6'h2A, 3'd7, 5'd31, 5'd0, 5'd17, 1'b1, 2'b10);
      shiftBits(32'(k), 0, 31, 1'b0);
      if (k < 3) begin
        checkOutput("bp_push_busy", 32'(o_busy), 32'd0);
        tick();
      end
    end
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_stall_busy",  32'(o_busy),   32'd1);
      checkOutput("bp_stall_head",  vpu.o_scalar,  32'd1);
      tick();
    end
    setReady(1'b1);
    checkOutput("bp_pop_busy",   32'(o_busy),   32'd0);
    checkOutput("bp_pop_scalar", vpu.o_scalar,  32'd1);
    tick();
    setReady(1'b0);
    checkOutput("bp_after_busy",   32'(o_busy),      32'd0);
    checkOutput("bp_after_valid",  32'(vpu.o_valid), 32'd1);
    checkOutput("bp_after_scalar", vpu.o_scalar,     32'd2);
    checkOutput("bp_after_cmd",    32'(vpu.o_cmd),   V2_CMD);
    setReady(1'b1);
    tick();
    checkOutput("bp_third_scalar", vpu.o_scalar,     32'd3);
    tick();
    checkOutput("bp_empty_valid",  32'(vpu.o_valid), 32'd0);
    setReady(1'b0);

    // Reset in the middle of shifting discards the partial operand
    $display("[TB] reset mid-shift");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 2'b00);
    shiftBits(32'hFFFF_FFFF, 0, 15, 1'b0);
    i_rst = 1'b1;
    #2;
    checkOutput("mrst_valid",  32'(vpu.o_valid), 32'd0);
    checkOutput("mrst_busy",   32'(o_busy),      32'd0);
    checkOutput("mrst_cmd",    32'(vpu.o_cmd),   32'd0);
    checkOutput("mrst_scalar", vpu.o_scalar,     32'd0);
    i_rst = 1'b0;
    tick();
    shiftBits(32'hFFFF_FFFF, 0, 31, 1'b0);
    tick();
    checkOutput("mrst_idle_valid", 32'(vpu.o_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 2'b00);
    shiftBits(32'h0000_0001, 0, 31, 1'b0);
    tick();
    checkOutput("mrst_next_valid",  32'(vpu.o_valid), 32'd1);
    checkOutput("mrst_next_scalar", vpu.o_scalar,     32'h0000_0001);
    checkOutput("mrst_next_cmd",    32'(vpu.o_cmd),   V1_CMD);
    drainOne("mrst");

    // Gapped counter enable: PUSH only after the 32nd enabled cycle
    $display("[TB] gapped cnt_en");
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h2A, 3'd7, 5'd31, 5'd0, 5'd17, 1'b1, 2'b10);
    shiftBits(32'h8000_0000, 0, 30, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("gap_wait_valid", 32'(vpu.o_valid), 32'd0);
      checkOutput("gap_wait_busy",  32'(o_busy),      32'd0);
    end
    shiftBits(32'h8000_0000, 31, 31, 1'b1);
`ifdef SERV_VPU_ISSUE_BYPASS_EN
    checkOutput("gap_push_valid", 32'(vpu.o_valid), 32'd1);
`else
    checkOutput("gap_push_valid", 32'(vpu.o_valid), 32'd0);
`endif
    tick();
    checkOutput("gap_valid",  32'(vpu.o_valid), 32'd1);
    checkOutput("gap_scalar", vpu.o_scalar,     32'h8000_0000);
    checkOutput("gap_cmd",    32'(vpu.o_cmd),   V2_CMD);
    drainOne("gap");

    // Ignored starts: no flags in IDLE, and a second start during SHIFT
    $display("[TB] ignored starts");
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    shiftBits(32'hFFFF_FFFF, 0, 31, 1'b0);
    checkOutput("noflag_valid", 32'(vpu.o_valid), 32'd0);
    tick();
    checkOutput("noflag_valid2", 32'(vpu.o_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 2'b00);
    shiftBits(32'h0F0F_1234, 0, 9, 1'b0);
    i_start = 1'b1; i_store_fp_op = 1'b1; i_funct6 = 6'h15; i_vd = 5'd9; i_vs1 = 5'd7; i_mop = 2'b01;
    tick();
    i_start = 1'b0; i_store_fp_op = 1'b0;
    shiftBits(32'h0F0F_1234, 10, 31, 1'b0);
    tick();
    checkOutput("midstart_valid",  32'(vpu.o_valid), 32'd1);
    checkOutput("midstart_cmd",    32'(vpu.o_cmd),   V1_CMD);
    checkOutput("midstart_scalar", vpu.o_scalar,     32'h0F0F_1234);
    drainOne("midstart");
    tick();
    checkOutput("midstart_no_extra", 32'(vpu.o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serv_vpu_issue.md
SERV_VPU_ISSUE -- requirements
Module: serv_vpu_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, issue FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  in  1  core clock; all state on rising edge.
REQ-003 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_start  in  1  one-cycle pulse marking instruction execution start.
REQ-005 SHALL have port i_vector_op / i_load_fp_op / i_store_fp_op  in  1 each  registered decode op-class flags.
REQ-006 SHALL have port i_funct3  in  3 and i_funct6  in  6  decode extension fields.
REQ-007 SHALL have port i_vd, i_vs1, i_vs2  in  5 each  vector register specifiers.
REQ-008 SHALL have port i_vm  in  1 and i_mop  in  2  mask bit and memory addressing mode.
REQ-009 SHALL have port i_cnt_en  in  1  bit-serial counter enable; one rs1 bit per asserted cycle.
REQ-010 SHALL have port i_rs1  in  1  serial rs1 operand, LSB first.
REQ-011 SHALL have port o_busy  out  1  stall request to core state machine.
REQ-012 SHALL have port o_valid  out  1 and i_ready  in  1  VPU command handshake.
REQ-013 SHALL have port o_cmd  out  29  packed command {type[1:0], funct6, funct3, vd, vs1, vs2, vm, mop}.
REQ-014 SHALL have port o_scalar  out  32  rs1 value accompanying o_cmd.

Function
REQ-015 SHALL encode type as 01 vector-arith, 10 load-fp, 11 store-fp; i_start with no flag set is ignored.
REQ-016 SHALL use FSM IDLE -> SHIFT on i_start with a flag set, latching all decode fields that cycle.
REQ-017 SHALL in SHIFT shift i_rs1 into bit 31 of a 32-bit register (right shift) on each i_cnt_en cycle; cycles without i_cnt_en hold.
REQ-018 SHALL count shifted bits in a 5-bit counter; on the 32nd bit (counter wrap 31->0) go to PUSH.
REQ-019 SHALL in PUSH write {cmd, scalar} into the FIFO if not full, then return to IDLE the next cycle.
REQ-020 SHALL in PUSH with FIFO full and no pop stay in PUSH with o_busy=1; o_busy=0 in all other cases.
REQ-021 SHALL accept a push into a full FIFO when a pop (o_valid & i_ready) occurs in the same cycle.
REQ-022 SHALL drive o_valid high whenever the FIFO is non-empty; o_cmd/o_scalar show the head entry, stable while o_valid & !i_ready.
REQ-023 SHALL pop the head on o_valid & i_ready; pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-024 SHALL ignore i_start while in SHIFT or PUSH (no relatch, no restart).
REQ-025 SHALL provide push-to-o_valid latency of one cycle (entry visible cycle after PUSH), unless REQ-031 applies.

Reset
REQ-026 SHALL on i_rst return FSM to IDLE, clear counter, shift register, FIFO pointers and count, at any time including mid-SHIFT.
REQ-027 SHALL reset o_valid=0, o_busy=0, o_cmd=0, o_scalar=0.
REQ-028 SHALL discard any partially shifted operand on reset; no entry is pushed.

Configuration
REQ-029 SHALL support macro SERV_VPU_ISSUE_BYPASS_EN.
REQ-030 SHALL without the macro always route commands through FIFO storage (REQ-025 latency).
REQ-031 SHALL with the macro, in PUSH with FIFO empty, drive o_valid=1 and o_cmd/o_scalar from PUSH data the same cycle; if i_ready=1 the entry is not written, else it is written normally.

Structure
REQ-032 SHALL place type encodings, command field widths/offsets and the 29-bit command typedef in shared package serv_vpu_pkg.
REQ-033 SHALL implement the FIFO as one sub-module serv_vpu_fifo (parameter DEPTH, width 61, push/pop/full/empty).

Verification
REQ-034 SHALL check: vector op funct6=0x00,funct3=0,vd=1,vs1=2,vs2=3, rs1=0xDEADBEEF serial, i_ready=1 -> one o_valid pulse, o_cmd type=01 fields match, o_scalar=0xDEADBEEF.
REQ-035 SHALL check: DEPTH=2, i_ready=0, three load-fp ops -> third holds o_busy=1 in PUSH; asserting i_ready for one cycle -> push accepted same cycle, o_busy drops.
REQ-036 SHALL check: i_rst asserted after 16 bits shifted -> o_valid=0, FSM IDLE; following op with rs1=0x00000001 delivers o_scalar=0x00000001.
REQ-037 SHALL check: i_cnt_en gapped (every other cycle) for rs1=0x80000000 -> o_scalar=0x80000000, PUSH after exactly 32 enabled cycles.
REQ-038 SHALL check: i_start with all flags 0, and i_start mid-SHIFT -> no FSM change, no extra entry.
REQ-039 SHALL check: with SERV_VPU_ISSUE_BYPASS_EN, empty FIFO, i_ready=1 -> o_valid high in the PUSH cycle, FIFO count stays 0.
